multiword_add_seq: RTL and testbench

Sequencer that performs multi-precision addition and subtraction on the team's combinational 16-bit adder ADDERFDS. Operands arrive word-serially, least-significant word first, over a valid/ready stream. The block drives the adder's operand and carry-in pins, captures its sum and carry-out, and propagates the carry from word to word. Each result word is emitted on a registered output stream. It sits directly upstream and downstream of ADDERFDS, which is instantiated beside it in the datapath wrapper.

---
 rtl/multiword_add_seq.sv | 143 ++++++++++++++
 tb/tb_multiword_add_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: word-serial multi-precision add/subtract sequencer
// wrapped around an external combinational 16-bit adder (ADDERFDS).
// Operands arrive LSW first; the carry between words is held locally.
// Each result word leaves through a single registered output stage.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // operand stream
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_sub,
  input  logic        in_last,
  // adder drive / return
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  // result stream
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
  output logic        out_ovf,
  output logic        out_err
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic {FIRST, MID} state_t;

  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_sum_q, out_sum_d;
  logic            out_last_q, out_last_d;
  logic            out_cout_q, out_cout_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_err_q, out_err_d;

  logic            eff_sub;
  logic            accept;
  logic            is_last;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

  // Adder drive and handshake: operation comes from in_sub on a packet's
  // first word and from the latched sub_q afterwards; subtraction is
  // A + ~B + 1 with the +1 entering as the first word's carry-in.
  always_comb begin
    eff_sub  = (state_q == FIRST) ? in_sub : sub_q;
    add_a    = in_a;
    add_b    = eff_sub ? ~in_b : in_b;
    add_cin  = (state_q == FIRST) ? in_sub : carry_q;
    in_ready = ~out_valid_q | out_ready;
    accept   = in_valid & in_ready;
    // A packet also ends when WORDS words arrive without in_last.
    is_last  = in_last | (cnt_q == LAST_IDX);
  end

  // Next-state: hold everything by default, drop valid on consume,
  // and load a fresh result (possibly in the same cycle) on accept.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      carry_d     = add_cout;
      if (state_q == FIRST) sub_d = in_sub;
      if (is_last) begin
        out_last_d = 1'b1;
        out_cout_d = add_cout;
        // Signed overflow on the top word: like-signed operands (after
        // B inversion) producing a result of the other sign.
        out_ovf_d  = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
        out_err_d  = ~in_last;
        state_d    = FIRST;
        cnt_d      = '0;
      end else begin
        out_last_d = 1'b0;
        out_cout_d = 1'b0;
        out_ovf_d  = 1'b0;
        out_err_d  = 1'b0;
        state_d    = MID;
        cnt_d      = cnt_q + 1'b1;
      end
    end
  end

  // State, carry chain and output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FIRST;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed vector table, randomised
// backpressure against a 64-bit reference, and a mid-packet reset.
module tb_multiword_add_seq;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_sub = 1'b0, in_last = 1'b0;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_last, out_cout, out_ovf, out_err;

  int n_cmp = 0;
  int n_bad = 0;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err)
  );

  // Behavioural stand-in for the ADDERFDS combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  // Packed result: {valid, last, cout, ovf, err, sum}
  function automatic logic [20:0] res(input logic v, l, c, o, e, input logic [15:0] s);
    return {v, l, c, o, e, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        sub, last;
    logic [15:0] sum;
    logic        olast, cout, ovf, err;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, b, input logic sub, last,
                              input logic [15:0] sum, input logic olast, cout, ovf, err);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.last = last;
    v.sum = sum; v.olast = olast; v.cout = cout; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  function automatic logic [20:0] out_now();
    return res(out_valid, out_last, out_cout, out_ovf, out_err, out_sum);
  endfunction

  // Backpressure data
  localparam int NP = 6;
  localparam int NW = NP * 4;
  logic [15:0] wa [NW];
  logic [15:0] wb [NW];
  logic        wsub [NP];
  logic [20:0] exp_o [NW];

  initial begin : main
    vec_t vecs [17];
    logic [63:0] A, B, Be, R;
    logic        C;
    int acc, got, cyc;
    logic acc_now;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out_now()), 32'(res(0,0,0,0,0,16'h0000)));
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed table ----
    // 64-bit add: 0xFFFF + 0x0001 ripples into word 1
    vecs[0]  = mk(16'hFFFF,16'h0001,0,0, 16'h0000,0,0,0,0);
    vecs[1]  = mk(16'h0000,16'h0000,0,0, 16'h0001,0,0,0,0);
    vecs[2]  = mk(16'h0000,16'h0000,0,0, 16'h0000,0,0,0,0);
    vecs[3]  = mk(16'h0000,16'h0000,0,1, 16'h0000,1,0,0,0);
    // 32-bit 0x0001_0000 - 0x0000_0001 = 0x0000_FFFF, no borrow
    vecs[4]  = mk(16'h0000,16'h0001,1,0, 16'hFFFF,0,0,0,0);
    vecs[5]  = mk(16'h0001,16'h0000,1,1, 16'h0000,1,1,0,0);
    // 32-bit 0 - 1 = 0xFFFF_FFFF, borrow
    vecs[6]  = mk(16'h0000,16'h0001,1,0, 16'hFFFF,0,0,0,0);
    vecs[7]  = mk(16'h0000,16'h0000,1,1, 16'hFFFF,1,0,0,0);
    // single-word signed overflow and unsigned carry
    vecs[8]  = mk(16'h7FFF,16'h0001,0,1, 16'h8000,1,0,1,0);
    vecs[9]  = mk(16'hFFFF,16'h0001,0,1, 16'h0000,1,1,0,0);
    // add packet with in_sub raised on word 2: must stay an add
    vecs[10] = mk(16'h0005,16'h0003,0,0, 16'h0008,0,0,0,0);
    vecs[11] = mk(16'h0001,16'h0001,1,1, 16'h0002,1,0,0,0);
    // truncation: 4 words without in_last, then 5th word starts a subtract
    vecs[12] = mk(16'hFFFF,16'h0001,0,0, 16'h0000,0,0,0,0);
    vecs[13] = mk(16'hFFFF,16'h0001,0,0, 16'h0001,0,0,0,0);
    vecs[14] = mk(16'hFFFF,16'h0001,0,0, 16'h0001,0,0,0,0);
    vecs[15] = mk(16'hFFFF,16'h0001,0,0, 16'h0001,1,1,0,1);
    vecs[16] = mk(16'h0005,16'h0001,1,1, 16'h0004,1,1,0,0);

    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_a = vecs[i].a; in_b = vecs[i].b;
      in_sub = vecs[i].sub; in_last = vecs[i].last;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'(out_now()),
            32'(res(1, vecs[i].olast, vecs[i].cout, vecs[i].ovf, vecs[i].err, vecs[i].sum)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    // ---- stall: output held, in_ready low ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111; in_sub = 1'b0; in_last = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h0F0F; in_b = 16'h0001;
    @(posedge clk); #1;
    check("stall_hold", 32'(out_now()), 32'(res(1,1,0,0,0,16'h2345)));
    check("stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", 32'(out_now()), 32'(res(1,1,0,0,0,16'h0F10)));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // ---- backpressure against 64-bit reference ----
    for (int p = 0; p < NP; p++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      if (p == 0) begin A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'h1; end
      wsub[p] = (p % 2 == 1);
      Be = wsub[p] ? ~B : B;
      {C, R} = {1'b0, A} + {1'b0, Be} + {64'd0, wsub[p]};
      for (int w = 0; w < 4; w++) begin
        wa[p*4+w] = A[w*16 +: 16];
        wb[p*4+w] = B[w*16 +: 16];
        exp_o[p*4+w] = (w == 3)
          ? res(1, 1, C, (A[63] == Be[63]) && (R[63] != A[63]), 0, R[w*16 +: 16])
          : res(1, 0, 0, 0, 0, R[w*16 +: 16]);
      end
    end

    acc = 0; got = 0; cyc = 0;
    while (got < NW && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (acc < NW) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = wa[acc]; in_b = wb[acc];
        in_last = (acc % 4 == 3);
        in_sub = (acc % 4 == 0) ? wsub[acc/4] : 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        check($sformatf("bp_word%0d", got), 32'(out_now()), 32'(exp_o[got]));
        got++;
      end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) acc++;
      cyc++;
    end
    check("bp_all_words", got, NW);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // ---- reset mid-packet ----
    in_valid = 1'b1; in_sub = 1'b0; in_last = 1'b0;
    in_a = 16'hFFFF; in_b = 16'h0001;
    @(posedge clk); #1;
    in_a = 16'h0001; in_b = 16'h0001;
    @(posedge clk); #1;
    check("pre_rst_word2", 32'(out_now()), 32'(res(1,0,0,0,0,16'h0003)));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_now()), 32'(res(0,0,0,0,0,16'h0000)));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1; in_a = 16'h0000; in_b = 16'h0000; in_last = (w == 3);
      @(posedge clk); #1;
      check($sformatf("post_rst_w%0d", w), 32'(out_now()),
            32'(res(1, w == 3, 0, 0, 0, 16'h0000)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
